// File: rtl/fft_pkg.sv
// Shared widths, FSM state type and complex-word layout for the
// FFT butterfly writeback path.
package fft_pkg;

    localparam int COMP_W = 17;
    localparam int CPLX_W = 34;
    localparam int BFLY_W = 136;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic signed [COMP_W-1:0] re;
        logic signed [COMP_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/bfly_writeback_cplx_sat.sv
// Combinational clamp of one complex word to the 16-bit signed range,
// kept in 17-bit sign-extended form.
module cplx_sat
    import fft_pkg::*;
(
    input  logic [CPLX_W-1:0] i_d,
    output logic [CPLX_W-1:0] o_d,
    output logic              o_sat
);

    localparam logic [COMP_W-1:0] SAT_MAX = 17'h07FFF;
    localparam logic [COMP_W-1:0] SAT_MIN = 17'h18000;

    cplx_t w_in;
    cplx_t w_out;
    logic  w_ovf_re;
    logic  w_ovf_im;

    assign w_in = cplx_t'(i_d);

    // Top two bits differ exactly when the value leaves [-32768, 32767].
    assign w_ovf_re = w_in.re[COMP_W-1] ^ w_in.re[COMP_W-2];
    assign w_ovf_im = w_in.im[COMP_W-1] ^ w_in.im[COMP_W-2];

    always_comb begin
        w_out = w_in;
        if (w_ovf_re) begin
            w_out.re = w_in.re[COMP_W-1] ? SAT_MIN : SAT_MAX;
        end
        if (w_ovf_im) begin
            w_out.im = w_in.im[COMP_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    assign o_d   = w_out;
    assign o_sat = w_ovf_re | w_ovf_im;

endmodule

// File: rtl/bfly_writeback.sv
// Serialises one radix-4 butterfly result into four strided memory writes.
// Define BFLY_WB_SAT_EN to clamp each component and report sat_flag.
module bfly_writeback
    import fft_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int GROUPS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BFLY_W-1:0] calc_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CPLX_W-1:0] wr_data,
    output logic              sat_flag,
    output logic              stage_done
);

    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);

    wb_state_t         r_state;
    logic [1:0]        r_beat;
    logic [GW-1:0]     r_grp;
    logic              r_live;
    logic [BFLY_W-1:0] r_calc;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_stride;

    logic              w_accept;
    logic              w_wdone;
    logic              w_last;
    logic [CPLX_W-1:0] w_word;

    assign wr_en    = (r_state == ST_WRITE);
    assign w_wdone  = wr_en & wr_ready;
    assign w_last   = w_wdone & (r_beat == 2'd3);
    // r_live holds ready low until the first edge after reset release.
    assign in_ready = r_live & ((r_state == ST_IDLE) | w_last);
    assign w_accept = in_valid & in_ready;

    assign w_word     = r_calc[CPLX_W*r_beat +: CPLX_W];
    assign wr_addr    = r_base + ADDR_W'(r_beat) * r_stride;
    assign stage_done = w_last & (r_grp == GRP_LAST);

`ifdef BFLY_WB_SAT_EN
    logic w_sat;

    cplx_sat u_sat (
        .i_d   (w_word),
        .o_d   (wr_data),
        .o_sat (w_sat)
    );

    assign sat_flag = w_sat & wr_en;
`else
    assign wr_data  = w_word;
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_beat   <= '0;
            r_grp    <= '0;
            r_live   <= 1'b0;
            r_calc   <= '0;
            r_base   <= '0;
            r_stride <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_calc   <= calc_in;
                r_base   <= base_addr;
                r_stride <= stride;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_WRITE;
                        r_beat  <= '0;
                    end
                end
                ST_WRITE: begin
                    if (w_wdone) begin
                        r_beat <= r_beat + 2'd1;
                        if (r_beat == 2'd3 && !w_accept) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_last) begin
                r_grp <= (r_grp == GRP_LAST) ? '0 : r_grp + GW'(1);
            end
        end
    end

endmodule
